// File: rtl/uart_acc_pkg.sv
// Shared types and constants for the UART frame accumulator.
// Contents: FSM state encoding, error code values, default terminator bytes,
// and a helper that recognises the byte that opens a terminator sequence.
package uart_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    TERM2 = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_PROTOCOL = 2'd3;

  localparam logic [7:0] DEF_TERM_SINGLE = 8'h0D;
  localparam logic [7:0] DEF_TERM_HI     = 8'hBE;
  localparam logic [7:0] DEF_TERM_LO     = 8'hEF;

  // True when byte b starts the terminator for the given mode
  // (the whole terminator in mode 0, its first byte in mode 1).
  function automatic logic term_start(input logic [7:0] b,
                                      input logic       dual,
                                      input logic [7:0] t_single,
                                      input logic [7:0] t_hi);
    return dual ? (b == t_hi) : (b == t_single);
  endfunction

endpackage

// File: rtl/uart_acc_timeout_timer.sv
// Inter-byte timeout counter for the UART frame accumulator.
// Latency: expired is combinational from the count, asserted in the cycle the
// count would reach TIMEOUT. No backpressure.
// Ports: clk, reset (async, active-high), clr (zero the count, wins over run),
// run (count this cycle), expired (one-cycle pulse at the TIMEOUT-th run cycle).
import uart_acc_pkg::*;

module uart_acc_timeout_timer #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  // The count only needs to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the expiry cycle itself.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = run && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_accumulator.sv
// Collects UART RX bytes into a frame until a single (mode 0) or dual (mode 1)
// terminator, then holds the frame on frame_valid/frame_ready.
// Latency: frame_valid is set by the edge sampling the last terminator byte;
// err_valid/overrun are registered one-cycle pulses. Backpressure: while a
// frame waits for frame_ready, incoming bytes are dropped and flagged on overrun.
// Ports: clk, reset (async, active-high); in_data/in_valid byte strobe; mode
// terminator select; frame_data/frame_len/frame_valid/frame_ready frame output;
// err_valid/err_code (1 overflow, 2 timeout, 3 protocol); overrun; busy.
// Build option: define UART_ACC_XOR_CHECK_EN to require the payload (including
// its trailing checksum byte) to XOR to zero before a frame is delivered.
import uart_acc_pkg::*;

module uart_frame_accumulator #(
  parameter int         MAX_BYTES   = 128,
  parameter int         TIMEOUT     = 2000,
  parameter logic [7:0] TERM_SINGLE = DEF_TERM_SINGLE,
  parameter logic [7:0] TERM_HI     = DEF_TERM_HI,
  parameter logic [7:0] TERM_LO     = DEF_TERM_LO,
  parameter int         LEN_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   mode,
  output logic [MAX_BYTES*8-1:0] frame_data,
  output logic [LEN_W-1:0]       frame_len,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic                   overrun,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [MAX_BYTES*8-1:0] data_q, data_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   mode_q, mode_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   err_valid_q, err_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   err_hit;
  logic [1:0]             err_kind;
  logic                   frame_ok;
  logic                   tmr_clr, tmr_run, tmr_expired;

`ifdef UART_ACC_XOR_CHECK_EN
  logic [7:0] xor_q, xor_d;
  assign frame_ok = (xor_q == 8'h00);
`else
  assign frame_ok = 1'b1;
`endif

  // Timer only runs while a frame is open and the line is quiet; any byte
  // (including one landing on the expiry cycle) restarts it.
  assign tmr_clr = in_valid || (state_q == IDLE) || (state_q == HOLD);
  assign tmr_run = ((state_q == ACCUM) || (state_q == TERM2)) && !in_valid;

  uart_acc_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    mode_d      = mode_q;
    err_code_d  = err_code_q;
    err_valid_d = 1'b0;
    overrun_d   = 1'b0;
    err_hit     = 1'b0;
    err_kind    = ERR_NONE;
`ifdef UART_ACC_XOR_CHECK_EN
    xor_d       = xor_q;
`endif

    unique case (state_q)
      IDLE: begin
        // A terminator with nothing before it is an empty frame: ignore it.
        if (in_valid && !term_start(in_data, mode, TERM_SINGLE, TERM_HI)) begin
          data_d      = '0;
          data_d[7:0] = in_data;
          len_d       = LEN_W'(1);
          mode_d      = mode;
          state_d     = ACCUM;
`ifdef UART_ACC_XOR_CHECK_EN
          xor_d       = in_data;
`endif
        end
      end

      ACCUM: begin
        if (in_valid) begin
          if (!mode_q && (in_data == TERM_SINGLE)) begin
            if (frame_ok) begin
              state_d = HOLD;
            end else begin
              err_hit  = 1'b1;
              err_kind = ERR_PROTOCOL;
            end
          end else if (mode_q && (in_data == TERM_HI)) begin
            state_d = TERM2;
          end else if (len_q < LEN_W'(MAX_BYTES)) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (len_q == LEN_W'(i)) begin
                data_d[8*i +: 8] = in_data;
              end
            end
            len_d = len_q + LEN_W'(1);
`ifdef UART_ACC_XOR_CHECK_EN
            xor_d = xor_q ^ in_data;
`endif
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_OVERFLOW;
          end
        end else if (tmr_expired) begin
          err_hit  = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end

      TERM2: begin
        if (in_valid) begin
          if ((in_data == TERM_LO) && frame_ok) begin
            state_d = HOLD;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_PROTOCOL;
          end
        end else if (tmr_expired) begin
          err_hit  = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end

      HOLD: begin
        // Frame is frozen until the consumer takes it; bytes are lost meanwhile.
        if (in_valid) begin
          overrun_d = 1'b1;
        end
        if (frame_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Any error abandons the partial frame; frame_valid is never raised for it.
    if (err_hit) begin
      state_d     = IDLE;
      err_valid_d = 1'b1;
      err_code_d  = err_kind;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_ACC_XOR_CHECK_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      err_code_q  <= err_code_d;
      err_valid_q <= err_valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_ACC_XOR_CHECK_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign frame_data  = data_q;
  assign frame_len   = len_q;
  assign frame_valid = (state_q == HOLD);
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Directed bench for uart_frame_accumulator with a small buffer and timeout.
module tb_uart_frame_accumulator;

  localparam int MB    = 8;
  localparam int TO    = 20;
  localparam int LW    = $clog2(MB + 1);

  logic            clk;
  logic            reset;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            mode;
  logic [MB*8-1:0] frame_data;
  logic [LW-1:0]   frame_len;
  logic            frame_valid;
  logic            frame_ready;
  logic            err_valid;
  logic [1:0]      err_code;
  logic            overrun;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;
  int ovr_base;
  int fv_cnt;

  uart_frame_accumulator #(
    .MAX_BYTES (MB),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .mode        (mode),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overrun pulses counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    mode        = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_fv",   frame_valid, 0);
    chk("rst_len",  frame_len,   0);
    chk("rst_data", frame_data,  0);
    chk("rst_err",  err_valid,   0);
    chk("rst_code", err_code,    0);
    chk("rst_ovr",  overrun,     0);
    chk("rst_busy", busy,        0);
    tick();

    // Mode 0 basic frame
    mode = 1'b0;
    frame_ready = 1'b1;
    send(8'h41);
    chk("m0_busy", busy, 1);
    send(8'h42);
    send(8'h43);
    chk("m0_fv_pre", frame_valid, 0);
    send(8'h0D);
    chk("m0_fv",   frame_valid, 1);
    chk("m0_len",  frame_len,   3);
    chk("m0_data", frame_data,  64'h0000_0000_0043_4241);
    tick();
    chk("m0_fv_gone", frame_valid, 0);
    chk("m0_idle",    busy,        0);
    chk("m0_keep",    frame_len,   3);

    // Reset mid-frame abandons the frame with no error
    send(8'h01);
    chk("mr_busy", busy, 1);
    chk("mr_len",  frame_len, 1);
    reset = 1'b1;
    #2;
    chk("mr_busy0", busy,      0);
    chk("mr_len0",  frame_len, 0);
    chk("mr_err",   err_valid, 0);
    reset = 1'b0;
    tick();

    // Terminators in IDLE are discarded
    send(8'h0D);
    chk("idle_t0_busy", busy, 0);
    chk("idle_t0_err",  err_valid, 0);
    mode = 1'b1;
    send(8'hBE);
    chk("idle_t1_busy", busy, 0);
    chk("idle_t1_fv",   frame_valid, 0);

    // Mode 1 frame with backpressure and an overrun byte
    frame_ready = 1'b0;
    ovr_base = ovr_cnt;
    send(8'h01);
    send(8'h02);
    send(8'hBE);
    chk("m1_term2_fv",   frame_valid, 0);
    chk("m1_term2_busy", busy,        1);
    send(8'hEF);
    fv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
      if (i == 3) begin
        in_data  = 8'h55;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
    end
    chk("m1_fv_cycles", fv_cnt,    10);
    chk("m1_len_hold",  frame_len, 2);
    frame_ready = 1'b1;
    tick();
    chk("m1_fv_gone", frame_valid, 0);
    chk("m1_len",     frame_len,   2);
    chk("m1_data",    frame_data,  64'h0201);
    chk("m1_overrun", ovr_cnt - ovr_base, 1);

    // Mode 1 protocol error
    send(8'h01);
    send(8'hBE);
    send(8'h02);
    chk("pe_err",  err_valid,   1);
    chk("pe_code", err_code,    3);
    chk("pe_fv",   frame_valid, 0);
    chk("pe_busy", busy,        0);
    tick();
    chk("pe_pulse", err_valid, 0);
    chk("pe_hold",  err_code,  3);

    // Mode 0 overflow on byte MB+1
    mode = 1'b0;
    for (int i = 0; i < MB; i++) send(8'h10 + 8'(i));
    chk("of_len",  frame_len, MB);
    chk("of_busy", busy,      1);
    chk("of_noerr", err_valid, 0);
    send(8'h20);
    chk("of_err",  err_valid, 1);
    chk("of_code", err_code,  1);
    chk("of_idle", busy,      0);
    chk("of_fv",   frame_valid, 0);

    // Timeout after TO idle cycles
    tick();
    send(8'h01);
    repeat (TO - 1) tick();
    chk("to_pre_err",  err_valid, 0);
    chk("to_pre_busy", busy,      1);
    tick();
    chk("to_err",  err_valid, 1);
    chk("to_code", err_code,  2);
    chk("to_idle", busy,      0);

    // Byte landing on the expiry cycle wins and restarts the timer
    tick();
    send(8'h01);
    repeat (TO - 1) tick();
    send(8'h02);
    chk("tb_noerr", err_valid, 0);
    chk("tb_busy",  busy,      1);
    chk("tb_len",   frame_len, 2);
    repeat (TO - 1) tick();
    chk("tb_pre_err", err_valid, 0);
    tick();
    chk("tb_err", err_valid, 1);
    tick();

`ifdef UART_ACC_XOR_CHECK_EN
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h0D);
    chk("xc_fv",   frame_valid, 1);
    chk("xc_len",  frame_len,   3);
    chk("xc_data", frame_data,  64'h33_2211);
    tick();
    send(8'h11);
    send(8'h22);
    send(8'h34);
    send(8'h0D);
    chk("xc_bad_err",  err_valid,   1);
    chk("xc_bad_code", err_code,    3);
    chk("xc_bad_fv",   frame_valid, 0);
`else
    send(8'h11);
    send(8'h22);
    send(8'h34);
    send(8'h0D);
    chk("nx_fv",   frame_valid, 1);
    chk("nx_len",  frame_len,   3);
    chk("nx_data", frame_data,  64'h34_2211);
    chk("nx_err",  err_valid,   0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad = bad + 1;
    $display("FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
